// File: rtl/vga_draw_scheduler.sv
// vga_draw_scheduler: shares the single VGA adapter port between the map
// drawer (client 0) and the sprite drawers (clients 1..NUM_CLIENTS-1).
// Each frame, the clients are started in fixed order. Only the active
// client's pixel stream reaches the adapter. A watchdog bounds each client,
// and a sticky overrun flag records frame ticks that land mid-frame.
module vga_draw_scheduler #(
  parameter int NUM_CLIENTS    = 5,
  parameter int FRAME_DIV      = 833333,
  parameter int TIMEOUT_CYCLES = 40000
) (
  input  logic                     clock_50,
  input  logic                     reset,
  input  logic                     en,
  output logic [NUM_CLIENTS-1:0]   client_start,
  input  logic [NUM_CLIENTS-1:0]   client_done,
  input  logic [NUM_CLIENTS-1:0]   client_plot,
  input  logic [8*NUM_CLIENTS-1:0] client_x,
  input  logic [8*NUM_CLIENTS-1:0] client_y,
  input  logic [3*NUM_CLIENTS-1:0] client_color,
  output logic                     vga_plot,
  output logic [7:0]               vga_x,
  output logic [7:0]               vga_y,
  output logic [2:0]               vga_color,
  output logic [2:0]               active_client,
  output logic                     frame_tick,
  output logic                     busy,
  output logic                     overrun,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {IDLE, START, DRAW, NEXT} state_t;

  localparam logic [19:0] FRAME_LAST = 20'(FRAME_DIV - 1);
  localparam logic [15:0] WD_LAST    = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  IDX_LAST   = 3'(NUM_CLIENTS - 1);

  state_t                 state, state_next;
  logic [2:0]             idx, idx_next;
  logic [15:0]            watchdog, watchdog_next;
  logic [19:0]            frame_count;
  logic                   timeout_hit;

  logic                   sel_done;
  logic                   sel_plot;
  logic [7:0]             sel_x;
  logic [7:0]             sel_y;
  logic [2:0]             sel_color;
  logic [NUM_CLIENTS-1:0] sel_onehot;

  // Free-running frame divider; frame_tick is registered one cycle after the last count.
  always_ff @(posedge clock_50) begin
    if (!reset) begin
      frame_count <= '0;
      frame_tick  <= 1'b0;
    end else begin
      frame_count <= (frame_count == FRAME_LAST) ? '0 : frame_count + 20'd1;
      frame_tick  <= (frame_count == FRAME_LAST);
    end
  end

  // Pick out the signals of the client addressed by idx.
  always_comb begin
    sel_done   = 1'b0;
    sel_plot   = 1'b0;
    sel_x      = '0;
    sel_y      = '0;
    sel_color  = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (idx == 3'(i)) begin
        sel_done      = client_done[i];
        sel_plot      = client_plot[i];
        sel_x         = client_x[8*i +: 8];
        sel_y         = client_y[8*i +: 8];
        sel_color     = client_color[3*i +: 3];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // State, client index, watchdog and sticky flags.
  always_ff @(posedge clock_50) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      watchdog    <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      watchdog <= watchdog_next;
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
      if (frame_tick && state != IDLE) begin
        overrun <= 1'b1;
      end
    end
  end

  // Next-state logic plus the start pulse and the adapter mux; the adapter is driven only in DRAW.
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    watchdog_next = watchdog;
    timeout_hit   = 1'b0;
    client_start  = '0;
    vga_plot      = 1'b0;
    vga_x         = '0;
    vga_y         = '0;
    vga_color     = '0;
    unique case (state)
      IDLE: begin
        if (frame_tick && en) begin
          state_next = START;
          idx_next   = '0;
        end
      end
      START: begin
        client_start  = sel_onehot;
        watchdog_next = '0;
        state_next    = DRAW;
      end
      DRAW: begin
        vga_plot      = sel_plot;
        vga_x         = sel_x;
        vga_y         = sel_y;
        vga_color     = sel_color;
        watchdog_next = watchdog + 16'd1;
        if (sel_done) begin
          state_next = NEXT;
        end else if (watchdog == WD_LAST) begin
          timeout_hit = 1'b1;
          state_next  = NEXT;
        end
      end
      NEXT: begin
        if (idx == IDX_LAST) begin
          idx_next   = '0;
          state_next = IDLE;
        end else begin
          idx_next   = idx + 3'd1;
          state_next = START;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy          = (state != IDLE);
  assign active_client = idx;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Randomized bench for vga_draw_scheduler. The bench plays every client and
// predicts each frame as a timeline of start/draw/next windows. The timeline
// is computed from the per-client done delays and the watchdog limit.
// The frame period is shortened so that watchdog-bounded frames can overrun.
module tb_vga_draw_scheduler;

  localparam int NC         = 3;
  localparam int FD         = 120;
  localparam int TO         = 50;
  localparam int NUM_CYCLES = 8000;

  logic            clock_50 = 1'b0;
  logic            reset;
  logic            en;
  logic [NC-1:0]   client_start;
  logic [NC-1:0]   client_done;
  logic [NC-1:0]   client_plot;
  logic [8*NC-1:0] client_x;
  logic [8*NC-1:0] client_y;
  logic [3*NC-1:0] client_color;
  logic            vga_plot;
  logic [7:0]      vga_x;
  logic [7:0]      vga_y;
  logic [2:0]      vga_color;
  logic [2:0]      active_client;
  logic            frame_tick;
  logic            busy;
  logic            overrun;
  logic            timeout_err;

  int checkCount = 0;
  int failCount  = 0;
  int cyc        = 0;

  // Frame timeline: client c is started at startAt[c] and drawn for drawLen[c] cycles.
  // doneDelay[c] is the number of cycles after start at which the client pulses done.
  bit frameOn;
  int startAt[NC];
  int drawLen[NC];
  int doneDelay[NC];
  int frameEnd;
  bit expOverrun;
  bit expTimeout;
  bit enPrev;

  always #5 clock_50 = ~clock_50;

  vga_draw_scheduler #(
    .NUM_CLIENTS(NC),
    .FRAME_DIV(FD),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock_50(clock_50),
    .reset(reset),
    .en(en),
    .client_start(client_start),
    .client_done(client_done),
    .client_plot(client_plot),
    .client_x(client_x),
    .client_y(client_y),
    .client_color(client_color),
    .vga_plot(vga_plot),
    .vga_x(vga_x),
    .vga_y(vga_y),
    .vga_color(vga_color),
    .active_client(active_client),
    .frame_tick(frame_tick),
    .busy(busy),
    .overrun(overrun),
    .timeout_err(timeout_err)
  );

  // Compares one observed value against the model and logs a failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // phase: 0 idle, 1 start, 2 draw, 3 next; client is the one owning that window.
  function automatic void modelPhase(input int k, output int phase, output int client);
    phase  = 0;
    client = 0;
    if (frameOn) begin
      for (int c = 0; c < NC; c++) begin
        if (k == startAt[c]) begin
          phase = 1; client = c;
        end else if (k > startAt[c] && k <= startAt[c] + drawLen[c]) begin
          phase = 2; client = c;
        end else if (k == startAt[c] + drawLen[c] + 1) begin
          phase = 3; client = c;
        end
      end
    end
  endfunction

  // Lays out a whole frame starting at cycle k, with random done delays.
  task automatic planFrame(input int k);
    int s = k;
    frameOn = 1'b1;
    for (int c = 0; c < NC; c++) begin
      int r = $urandom_range(0, 99);
      if (r < 50)      doneDelay[c] = $urandom_range(1, 40);
      else if (r < 70) doneDelay[c] = TO;
      else             doneDelay[c] = $urandom_range(TO + 1, TO + 20);
      drawLen[c] = (doneDelay[c] < TO) ? doneDelay[c] : TO;
      startAt[c] = s;
      s = s + drawLen[c] + 2;
    end
    frameEnd = startAt[NC-1] + drawLen[NC-1] + 1;
  endtask

  // Moves the model from cycle k-1 to cycle k.
  task automatic modelAdvance(input int k);
    int  ph, cl;
    int  prev = k - 1;
    modelPhase(prev, ph, cl);
    if (prev > 0 && prev % FD == 0) begin
      if (ph != 0)     expOverrun = 1'b1;
      else if (enPrev) planFrame(k);
    end
    if (frameOn) begin
      for (int c = 0; c < NC; c++) begin
        if (doneDelay[c] > TO && k == startAt[c] + TO + 1) expTimeout = 1'b1;
      end
    end
  endtask

  task automatic modelReset();
    frameOn    = 1'b0;
    expOverrun = 1'b0;
    expTimeout = 1'b0;
  endtask

  // Drives the clients for the current cycle; the active client's done is scripted, the rest is noise.
  task automatic applyStimulus(input int phase, input int client);
    if ($urandom_range(0, 99) < 2) en = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < NC; i++) begin
      if (phase == 2 && i == client) client_done[i] = (cyc == startAt[i] + doneDelay[i]);
      else                           client_done[i] = ($urandom_range(0, 15) == 0);
    end
    client_plot  = NC'($urandom);
    client_x     = 24'($urandom);
    client_y     = 24'($urandom);
    client_color = 9'($urandom);
  endtask

  initial begin
    int  ph, cl;
    bit  midResetDone = 1'b0;
    reset        = 1'b0;
    en           = 1'b1;
    client_done  = '0;
    client_plot  = '0;
    client_x     = '0;
    client_y     = '0;
    client_color = '0;
    modelReset();
    repeat (2) @(posedge clock_50);
    cyc = 0;
    for (int n = 0; n < NUM_CYCLES; n++) begin
      #1;
      reset = 1'b1;
      modelPhase(cyc, ph, cl);
      applyStimulus(ph, cl);
      #1;
      checkOutput("client_start", 32'(client_start), (ph == 1) ? (32'd1 << cl) : 32'd0);
      checkOutput("vga_plot",  32'(vga_plot),  (ph == 2) ? 32'(client_plot[cl])      : 32'd0);
      checkOutput("vga_x",     32'(vga_x),     (ph == 2) ? 32'(client_x[8*cl +: 8])  : 32'd0);
      checkOutput("vga_y",     32'(vga_y),     (ph == 2) ? 32'(client_y[8*cl +: 8])  : 32'd0);
      checkOutput("vga_color", 32'(vga_color), (ph == 2) ? 32'(client_color[3*cl +: 3]) : 32'd0);
      checkOutput("busy",          32'(busy),          32'(ph != 0));
      checkOutput("active_client", 32'(active_client), 32'(cl));
      checkOutput("frame_tick",    32'(frame_tick),    32'(cyc > 0 && cyc % FD == 0));
      checkOutput("overrun",       32'(overrun),       32'(expOverrun));
      checkOutput("timeout_err",   32'(timeout_err),   32'(expTimeout));
      enPrev = en;
      if (!midResetDone && n > NUM_CYCLES / 2 && ph == 2) begin
        midResetDone = 1'b1;
        reset = 1'b0;
      end
      @(posedge clock_50);
      if (!reset) begin
        cyc = 0;
        modelReset();
      end else begin
        cyc++;
        modelAdvance(cyc);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
